// File: rtl/inst_fetch_icache_if.sv
// Bus bundle for the instruction-fetch stage.
// master : the fetch stage (drives mem_req/mem_addr and the instruction outputs).
// slave  : its environment (ROB/decoder control plus the memory controller PC port).
// Signals:
//   rdy, clear, clear_pc, stall     control from the pipeline
//   mem_req, mem_addr               fetch request to the memory controller
//   mem_valid, mem_inst             returned instruction word
//   inst_valid, inst_out, inst_pc   instruction delivered to decode/issue
interface inst_fetch_icache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  rdy;
    logic                  clear;
    logic [ADDR_WIDTH-1:0] clear_pc;
    logic                  stall;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_valid;
    logic [INST_WIDTH-1:0] mem_inst;
    logic                  inst_valid;
    logic [INST_WIDTH-1:0] inst_out;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        input  rdy, clear, clear_pc, stall, mem_valid, mem_inst,
        output mem_req, mem_addr, inst_valid, inst_out, inst_pc
    );

    modport slave (
        output rdy, clear, clear_pc, stall, mem_valid, mem_inst,
        input  mem_req, mem_addr, inst_valid, inst_out, inst_pc
    );
endinterface

// File: rtl/inst_fetch_icache.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line I-cache.
// Holds the fetch PC, looks it up, issues a single word request on a miss,
// refills the line and replays the lookup. Delivers one instruction per
// cycle on hits and redirects on clear.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  inst_fetch_icache_if.master (control, memory port, instruction output)
module inst_fetch_icache #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    INDEX_BITS = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                 clk,
    input logic                 rst,
    inst_fetch_icache_if.master bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic {FETCH, WAIT_MEM} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
    logic                  r_mem_req, w_mem_req_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
    logic                  r_inst_valid, w_inst_valid_nxt;
    logic [INST_WIDTH-1:0] r_inst_out, w_inst_out_nxt;
    logic [ADDR_WIDTH-1:0] r_inst_pc, w_inst_pc_nxt;

    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [INST_WIDTH-1:0] r_data [LINES];

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_fill;
    logic                  w_unused_bits;

    assign w_index       = r_pc[INDEX_BITS+1:2];
    assign w_tag         = r_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_unused_bits = &{1'b0, bus.clear_pc[1:0]};

    // A refill only lands when enabled, not flushed, and a request is outstanding.
    assign w_fill = bus.rdy && !bus.clear && (r_state == WAIT_MEM) && bus.mem_valid;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_mem_req_nxt    = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_inst_valid_nxt = 1'b0;
        w_inst_out_nxt   = r_inst_out;
        w_inst_pc_nxt    = r_inst_pc;
        if (bus.clear) begin
            w_pc_nxt    = {bus.clear_pc[ADDR_WIDTH-1:2], 2'b00};
            w_state_nxt = FETCH;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (!bus.stall) begin
                        if (w_hit) begin
                            w_inst_valid_nxt = 1'b1;
                            w_inst_out_nxt   = r_data[w_index];
                            w_inst_pc_nxt    = r_pc;
                            w_pc_nxt         = r_pc + ADDR_WIDTH'(4);
                        end else begin
                            w_mem_req_nxt  = 1'b1;
                            w_mem_addr_nxt = r_pc;
                            w_state_nxt    = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_valid) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_inst_valid <= 1'b0;
            r_inst_out   <= '0;
            r_inst_pc    <= '0;
            r_valid      <= '0;
        end else if (bus.rdy) begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst_out   <= w_inst_out_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            if (w_fill) begin
                r_valid[w_index] <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone guard them.
    always_ff @(posedge clk) begin
        if (!rst && w_fill) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= bus.mem_inst;
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst_out   = r_inst_out;
    assign bus.inst_pc    = r_inst_pc;
endmodule

// File: tb/tb_inst_fetch_icache.sv
module tb_inst_fetch_icache;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    inst_fetch_icache_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

    inst_fetch_icache #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .INDEX_BITS(6),
        .RESET_PC  (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_miss(input string tag, input logic [31:0] addr);
        tick();
        chk({tag, "_req"}, 64'(bus.mem_req), 64'd1);
        chk({tag, "_addr"}, 64'(bus.mem_addr), 64'(addr));
        chk({tag, "_nov"}, 64'(bus.inst_valid), 64'd0);
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        tick();
        chk({tag, "_v"}, 64'(bus.inst_valid), 64'd1);
        chk({tag, "_pc"}, 64'(bus.inst_pc), 64'(pc));
        chk({tag, "_inst"}, 64'(bus.inst_out), 64'(inst));
        chk({tag, "_noreq"}, 64'(bus.mem_req), 64'd0);
    endtask

    // Called right after mem_req was seen; returns after the refill edge.
    task automatic refill(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                          input int lat);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk({tag, "_hold_req"}, 64'(bus.mem_req), 64'd0);
            chk({tag, "_hold_addr"}, 64'(bus.mem_addr), 64'(addr));
        end
        bus.mem_valid = 1'b1;
        bus.mem_inst  = inst;
        tick();
        bus.mem_valid = 1'b0;
        bus.mem_inst  = 32'h0;
        chk({tag, "_fill_nov"}, 64'(bus.inst_valid), 64'd0);
    endtask

    task automatic redirect(input string tag, input logic [31:0] pc);
        bus.clear    = 1'b1;
        bus.clear_pc = pc;
        tick();
        bus.clear    = 1'b0;
        chk({tag, "_clr_req"}, 64'(bus.mem_req), 64'd0);
        chk({tag, "_clr_nov"}, 64'(bus.inst_valid), 64'd0);
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        bus.rdy       = 1'b1;
        bus.clear     = 1'b0;
        bus.clear_pc  = 32'h0;
        bus.stall     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_inst  = 32'h0;

        tick();
        tick();
        chk("rst_req", 64'(bus.mem_req), 64'd0);
        chk("rst_v", 64'(bus.inst_valid), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_inst", 64'(bus.inst_out), 64'd0);
        chk("rst_pc", 64'(bus.inst_pc), 64'd0);
        rst = 1'b0;

        // Cold start: miss at 0, four-cycle memory, hit two cycles after mem_valid.
        expect_miss("cold", 32'h0);
        refill("cold", 32'h0, 32'h0000_0093, 4);
        expect_hit("cold_hit", 32'h0, 32'h0000_0093);
        expect_miss("cold_next", 32'h4);

        // Preload 0x4..0xC.
        refill("pre4", 32'h4, 32'hA000_0004, 1);
        expect_hit("pre4_hit", 32'h4, 32'hA000_0004);
        expect_miss("pre8", 32'h8);
        refill("pre8", 32'h8, 32'hA000_0008, 1);
        expect_hit("pre8_hit", 32'h8, 32'hA000_0008);
        expect_miss("preC", 32'hC);
        refill("preC", 32'hC, 32'hA000_000C, 1);
        expect_hit("preC_hit", 32'hC, 32'hA000_000C);
        expect_miss("pre10", 32'h10);

        // Warm loop: abandon the 0x10 miss, four back-to-back hits.
        redirect("warm", 32'h0);
        expect_hit("warm0", 32'h0, 32'h0000_0093);
        expect_hit("warm4", 32'h4, 32'hA000_0004);
        expect_hit("warm8", 32'h8, 32'hA000_0008);
        expect_hit("warmC", 32'hC, 32'hA000_000C);

        // Stall for three cycles between hits.
        redirect("stl", 32'h0);
        expect_hit("stl0", 32'h0, 32'h0000_0093);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_nov", 64'(bus.inst_valid), 64'd0);
            chk("stl_noreq", 64'(bus.mem_req), 64'd0);
        end
        bus.stall = 1'b0;
        expect_hit("stl4", 32'h4, 32'hA000_0004);
        expect_hit("stl8", 32'h8, 32'hA000_0008);

        // Conflict: 0x100 evicts 0x000 at index 0.
        redirect("cf", 32'h100);
        expect_miss("cf100", 32'h100);
        refill("cf100", 32'h100, 32'hA000_0100, 2);
        expect_hit("cf100_hit", 32'h100, 32'hA000_0100);
        redirect("cf0", 32'h0);
        expect_miss("cf0", 32'h0);
        refill("cf0", 32'h0, 32'h0000_0093, 2);
        expect_hit("cf0_hit", 32'h0, 32'h0000_0093);

        // Clear mid-miss with a coincident mem_valid: the refill is dropped.
        redirect("cm", 32'h200);
        expect_miss("cm200", 32'h200);
        tick();
        bus.clear     = 1'b1;
        bus.clear_pc  = 32'h203;
        bus.mem_valid = 1'b1;
        bus.mem_inst  = 32'hDEAD_BEEF;
        tick();
        bus.clear     = 1'b0;
        bus.mem_valid = 1'b0;
        chk("cm_clr_req", 64'(bus.mem_req), 64'd0);
        chk("cm_clr_nov", 64'(bus.inst_valid), 64'd0);
        expect_miss("cm_rereq", 32'h200);
        refill("cm_fill", 32'h200, 32'hA000_0200, 1);
        expect_hit("cm_hit", 32'h200, 32'hA000_0200);

        // rdy low for five cycles while mem_valid toggles.
        expect_miss("rdy", 32'h204);
        bus.rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_valid = ~bus.mem_valid;
            bus.mem_inst  = 32'hBAD0_0BAD;
            tick();
            chk("rdy_hold_req", 64'(bus.mem_req), 64'd1);
            chk("rdy_hold_addr", 64'(bus.mem_addr), 64'h204);
            chk("rdy_hold_nov", 64'(bus.inst_valid), 64'd0);
        end
        bus.rdy       = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_inst  = 32'h0;
        refill("rdy_fill", 32'h204, 32'hA000_0204, 2);
        expect_hit("rdy_hit", 32'h204, 32'hA000_0204);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/inst_fetch_icache.md
Name: inst_fetch_icache

Overview:
- Instruction-fetch stage with a direct-mapped instruction cache, placed directly upstream of the memory controller's PC port.
- Holds the architectural fetch PC and looks the PC up in the cache.
- On a miss, it issues a single word request to the memory controller, refills the line, then replays the lookup.
- Delivers one instruction per cycle to the decoder/issue stage and redirects on `clear` (branch mispredict / flush).

Parameters:
- ADDR_WIDTH, 32, width of PC and memory addresses
- INST_WIDTH, 32, instruction width
- INDEX_BITS, 6, log2 of cache lines (64 lines, one 32-bit instruction per line)
- RESET_PC, 32'h0, PC loaded on reset

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- rdy  input  1  global enable; when low all state and outputs hold
- clear  input  1  flush/redirect request from ROB
- clear_pc  input  ADDR_WIDTH  redirect target, valid with clear
- stall  input  1  downstream cannot accept an instruction this cycle
- mem_req  output  1  one-cycle fetch request pulse to memory controller
- mem_addr  output  ADDR_WIDTH  fetch address; held stable from mem_req until mem_valid or clear
- mem_valid  input  1  one-cycle pulse, mem_inst is valid
- mem_inst  input  INST_WIDTH  little-endian assembled word from memory
- inst_valid  output  1  inst_out/inst_pc valid this cycle (single-cycle pulse per instruction)
- inst_out  output  INST_WIDTH  fetched instruction
- inst_pc  output  ADDR_WIDTH  address of inst_out

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2]
  - tag = pc[ADDR_WIDTH-1:INDEX_BITS+2]
  - pc[1:0] ignored and always 0
- Storage per line: valid bit, tag, data.
- Reset (rst high at posedge, takes priority over everything):
  - all valid bits <= 0
  - pc <= RESET_PC
  - state <= FETCH
  - mem_req, inst_valid <= 0
  - mem_addr, inst_out, inst_pc <= 0
- rdy low: nothing changes, no outputs update, mem_valid ignored.
- Default each enabled cycle: mem_req <= 0, inst_valid <= 0.
- State FETCH:
  - stall high: no lookup; pc unchanged.
  - Hit (valid[index] and tag match):
    - inst_valid <= 1, inst_out <= data[index], inst_pc <= pc
    - pc <= pc + 4 (wraps modulo 2^ADDR_WIDTH)
    - Hit-to-output latency is 1 cycle, so back-to-back hits give 1 instruction/cycle.
  - Miss:
    - mem_req <= 1, mem_addr <= pc
    - state <= WAIT_MEM
    - no output this cycle
- State WAIT_MEM:
  - mem_req stays 0 after the first pulse; mem_addr is held.
  - On mem_valid:
    - data[index] <= mem_inst, tag[index] <= tag(pc), valid[index] <= 1
    - state <= FETCH (the next cycle re-looks up and hits)
  - Miss penalty = memory latency + 2 cycles.
  - stall has no effect in WAIT_MEM; the refill completes regardless.
- clear (priority over all non-reset activity, any state):
  - pc <= {clear_pc[ADDR_WIDTH-1:2], 2'b00}
  - state <= FETCH
  - inst_valid <= 0, mem_req <= 0
  - Any outstanding miss is abandoned; the memory controller is flushed by the same clear.
  - mem_valid in the same cycle as clear is discarded: no cache write.
  - Cache contents (valid bits) are preserved across clear.
- Cache-replacement boundaries:
  - A refill overwrites the line at its index unconditionally, including lines that are valid with a different tag.
  - No self-modifying-code support: stores do not invalidate the cache.
- At most one memory request outstanding; mem_req is never re-asserted while in WAIT_MEM.
- mem_valid arriving in FETCH (no request outstanding) is ignored.

Test Plan:
- Cold start: reset, RESET_PC=0, mem returns 32'h00000093 four cycles after mem_req.
  - Required: mem_req pulse with mem_addr=0.
  - Required: inst_valid with inst_out=32'h00000093, inst_pc=0 exactly 2 cycles after mem_valid.
  - Required: next request at mem_addr=4.
- Warm loop: PCs 0x0..0xC preloaded, clear to 0x0.
  - Required: four consecutive inst_valid cycles, inst_pc 0,4,8,C, no mem_req.
- Stall: during hits, stall high for 3 cycles.
  - Required: inst_valid=0 and pc frozen during stall.
  - Required: resumes with the next PC with no skipped or duplicated instruction.
- Conflict: fetch 0x000 then 0x100 (INDEX_BITS=6, same index).
  - Required: both miss.
  - Required: refetch of 0x000 misses again with mem_addr=0x000.
- Clear mid-miss: clear with clear_pc=0x203 while in WAIT_MEM, mem_valid in the same cycle.
  - Required: no cache write; pc=0x200; new mem_req with mem_addr=0x200 next cycle.
- rdy low for 5 cycles while mem_valid pulses.
  - Required: no state change, no refill.
  - Required: after rdy returns, behaviour continues from the frozen state.
